// File: rtl/timer_arbiter_pkg.sv
// Shared game timing package: FSM encoding, requester count, default clock
// rate and the round-robin search helper used by the arbiter.
package timer_arbiter_pkg;

    localparam int REQ_COUNT          = 4;
    localparam int DEFAULT_CLOCK_FREQ = 100_000_000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Returns {found, index}: the first asserted request at or after ptr,
    // wrapping 3 -> 0.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/timer_arbiter_core.sv
// Fractional-second timer: latches a 4-bit fraction on load, derives the
// period CLOCK_FREQ/fraction (fraction 0 means a full second) and counts it
// out, flagging the midpoint cycle and the final cycle of the period.
module frac_timer_core
    import timer_arbiter_pkg::*;
#(
    parameter int CLOCK_FREQ = DEFAULT_CLOCK_FREQ
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] fraction,
    output logic       expired,
    output logic       mid
);

    localparam logic [31:0] FREQ = 32'(CLOCK_FREQ);

    logic [3:0]  frac_q,   frac_d;
    logic [31:0] count_q,  count_d;
    logic        active_q, active_d;
    logic [31:0] period;
    logic [31:0] half;

    // Period is derived from the latched fraction so it cannot change mid-run;
    // a zero-length period is clamped to one cycle.
    always_comb begin
        period = (frac_q == 4'd0) ? FREQ : FREQ / {28'd0, frac_q};
        if (period == 32'd0) begin
            period = 32'd1;
        end
        half    = period >> 1;
        expired = active_q && (count_q == period - 32'd1);
        mid     = active_q && (half != 32'd0) && (count_q == half - 32'd1);
    end

    // Next-state: load restarts the count, otherwise count until the last cycle.
    always_comb begin
        frac_d   = frac_q;
        count_d  = count_q;
        active_d = active_q;
        if (load) begin
            frac_d   = fraction;
            count_d  = 32'd0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (expired) begin
                active_d = 1'b0;
                count_d  = 32'd0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
    end

    // Timer registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frac_q   <= 4'd0;
            count_q  <= 32'd0;
            active_q <= 1'b0;
        end else begin
            frac_q   <= frac_d;
            count_q  <= count_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one fractional-second timer among four
// requesters. Handshake: a requester raises req[i] and holds it; grant[i]
// marks ownership; done_out[i] pulses the cycle after the period completes;
// dropping req[i] while granted aborts the run without any pulse.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = REQ_COUNT,
    parameter int CLOCK_FREQ = DEFAULT_CLOCK_FREQ
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   fraction_in,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic [NUM_REQ-1:0]     done_out,
    output logic [NUM_REQ-1:0]     halfway_out,
    output logic                   dbg_state
);

    state_e     state_q,  state_d;
    logic [1:0] owner_q,  owner_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0] done_q,   done_d;

    logic [2:0] pick;
    logic       pick_found;
    logic [1:0] pick_idx;
    logic       core_load;
    logic [3:0] core_frac;
    logic       core_expired;
    logic       core_mid;
    logic [3:0] owner_onehot;

    assign pick         = rr_pick(req, rr_ptr_q);
    assign pick_found   = pick[2];
    assign pick_idx     = pick[1:0];
    assign owner_onehot = 4'b0001 << owner_q;

    frac_timer_core #(
        .CLOCK_FREQ (CLOCK_FREQ)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (core_load),
        .fraction (core_frac),
        .expired  (core_expired),
        .mid      (core_mid)
    );

    // FSM next-state: grant from IDLE, finish or abort from RUN. Abort wins
    // over completion so a cancelled run never reports done.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        done_d    = 4'd0;
        core_load = 1'b0;
        core_frac = fraction_in[{pick_idx, 2'b00} +: 4];
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d   = ST_RUN;
                    owner_d   = pick_idx;
                    core_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (!req[owner_q]) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_q + 2'd1;
                end else if (core_expired) begin
                    state_d  = ST_IDLE;
                    done_d   = owner_onehot;
                    rr_ptr_d = owner_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and arbitration registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= 2'd0;
            rr_ptr_q <= 2'd0;
            done_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            done_q   <= done_d;
        end
    end

    // Output steering to the current owner; the midpoint pulse is withheld
    // if the owner has already dropped its request.
    always_comb begin
        grant       = (state_q == ST_RUN) ? owner_onehot : 4'd0;
        busy        = (state_q == ST_RUN);
        done_out    = done_q;
        halfway_out = (state_q == ST_RUN && core_mid && req[owner_q]) ? owner_onehot : 4'd0;
        dbg_state   = state_q;
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with CLOCK_FREQ=16: a cycle model checks
// every output each cycle, and per-scenario logs are checked against
// hand-computed literals.
module tb_timer_arbiter;

    localparam int CF = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] fraction_in;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  done_out;
    logic [3:0]  halfway_out;
    logic        dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model of the shared timer
    bit         m_run;
    int         m_owner;
    int         m_count;
    int         m_period;
    int         m_rr;
    logic [3:0] m_done;

    // Per-cycle log of observed outputs for literal checks
    logic [3:0] lg_grant [64];
    logic [3:0] lg_half  [64];
    logic [3:0] lg_done  [64];
    int         lg_n = 64;

    timer_arbiter #(
        .NUM_REQ    (4),
        .CLOCK_FREQ (CF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .fraction_in (fraction_in),
        .grant       (grant),
        .busy        (busy),
        .done_out    (done_out),
        .halfway_out (halfway_out),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one run at a time, period = CF / fraction, abort on dropped request
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run = 0; m_owner = 0; m_count = 0; m_period = CF; m_rr = 0; m_done = 4'd0;
        end else begin
            m_done = 4'd0;
            if (m_run) begin
                if (!req[m_owner]) begin
                    m_run = 0;
                    m_rr  = (m_owner + 1) % 4;
                end else if (m_count == m_period - 1) begin
                    m_run  = 0;
                    m_done = 4'b0001 << m_owner;
                    m_rr   = (m_owner + 1) % 4;
                end else begin
                    m_count++;
                end
            end else if (req != 4'd0) begin
                bit found;
                found = 0;
                for (int k = 0; k < 4; k++) begin
                    int idx;
                    int fr;
                    idx = (m_rr + k) % 4;
                    if (!found && req[idx]) begin
                        found    = 1;
                        fr       = int'(fraction_in[idx*4 +: 4]);
                        m_owner  = idx;
                        m_period = (fr == 0) ? CF : CF / fr;
                        m_count  = 0;
                        m_run    = 1;
                    end
                end
            end
        end
    end

    // Compare process: every cycle, shortly after the rising edge
    always @(posedge clk) begin
        logic [3:0] eg;
        logic [3:0] eh;
        #2;
        eg = m_run ? (4'b0001 << m_owner) : 4'd0;
        eh = (m_run && req[m_owner] && (m_period / 2 > 0) && (m_count == m_period / 2 - 1))
             ? (4'b0001 << m_owner) : 4'd0;
        check("grant",   32'(grant),       32'(eg));
        check("busy",    32'(busy),        32'(m_run));
        check("done",    32'(done_out),    32'(m_done));
        check("halfway", 32'(halfway_out), 32'(eh));
        if (lg_n < 64) begin
            lg_grant[lg_n] = grant;
            lg_half[lg_n]  = halfway_out;
            lg_done[lg_n]  = done_out;
            lg_n++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        req = 4'd0;
        fraction_in = 16'd0;
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant),       32'd0);
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_done",  32'(done_out),    32'd0);
        check("rst_half",  32'(halfway_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single requester, fraction 4 -> P = 4
        fraction_in = 16'h0004; req = 4'b0001; lg_n = 0;
        repeat (5) @(negedge clk);
        req = 4'd0;
        repeat (3) @(negedge clk);
        for (int j = 0; j < 4; j++) check("s1_grant", 32'(lg_grant[j]), 32'h1);
        check("s1_grant_end", 32'(lg_grant[4]), 32'h0);
        check("s1_half0",     32'(lg_half[0]),  32'h0);
        check("s1_half1",     32'(lg_half[1]),  32'h1);
        check("s1_done3",     32'(lg_done[3]),  32'h0);
        check("s1_done4",     32'(lg_done[4]),  32'h1);

        // All four requesting, fraction 8 -> P = 2, rotation with idle gaps
        do_reset();
        fraction_in = 16'h8888; req = 4'b1111; lg_n = 0;
        repeat (15) @(negedge clk);
        req = 4'd0;
        repeat (2) @(negedge clk);
        for (int j = 0; j < 15; j++) begin
            logic [3:0] e;
            e = (j % 3 == 2) ? 4'd0 : (4'b0001 << ((j / 3) % 4));
            check("s2_rotation", 32'(lg_grant[j]), 32'(e));
        end

        // Fraction 0 -> full period of 16 cycles
        do_reset();
        fraction_in = 16'h0000; req = 4'b0010; lg_n = 0;
        repeat (17) @(negedge clk);
        req = 4'd0;
        repeat (2) @(negedge clk);
        cnt = 0;
        for (int j = 0; j < 18; j++) if (lg_grant[j] == 4'b0010) cnt++;
        check("s3_grant_len", 32'(cnt), 32'd16);
        check("s3_grant_end", 32'(lg_grant[16]), 32'h0);
        cnt = 0;
        for (int j = 0; j < 18; j++) if (lg_half[j] != 4'd0) cnt++;
        check("s3_half_cnt", 32'(cnt), 32'd1);
        check("s3_half7",    32'(lg_half[7]), 32'h2);
        cnt = 0;
        for (int j = 0; j < 18; j++) if (lg_done[j] != 4'd0) cnt++;
        check("s3_done_cnt", 32'(cnt), 32'd1);
        check("s3_done16",   32'(lg_done[16]), 32'h2);

        // Abort: owner 0 (P = 8) drops at counter 3, requester 2 is next
        do_reset();
        fraction_in = 16'h0002; req = 4'b0101; lg_n = 0;
        repeat (4) @(negedge clk);
        req = 4'b0100;
        repeat (2) @(negedge clk);
        req = 4'd0;
        repeat (3) @(negedge clk);
        check("s4_grant3", 32'(lg_grant[3]), 32'h1);
        check("s4_half3",  32'(lg_half[3]),  32'h1);
        check("s4_grant4", 32'(lg_grant[4]), 32'h0);
        check("s4_grant5", 32'(lg_grant[5]), 32'h4);
        cnt = 0;
        for (int j = 0; j < 9; j++) if (lg_done[j] != 4'd0) cnt++;
        check("s4_no_done", 32'(cnt), 32'd0);

        // Asynchronous reset mid-run at counter 5
        do_reset();
        fraction_in = 16'h0002; req = 4'b0001; lg_n = 0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        check("s5_grant_c5", 32'(lg_grant[5]), 32'h1);
        reset = 1'b1;
        req = 4'b0100;
        #1;
        check("s5_rst_grant", 32'(grant),       32'd0);
        check("s5_rst_busy",  32'(busy),        32'd0);
        check("s5_rst_done",  32'(done_out),    32'd0);
        check("s5_rst_half",  32'(halfway_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        lg_n = 0;
        repeat (3) @(negedge clk);
        check("s5_first_grant", 32'(lg_grant[0]), 32'h4);
        req = 4'd0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters (fixed at 4 in this revision).
REQ-002 Parameter: CLOCK_FREQ, 100_000_000, clk cycles per one-second period.
REQ-003 clk  in  1  clock, all state on rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 req  in  4  level request per requester; requester holds high until its done pulse, or drops it to cancel.
REQ-006 fraction_in  in  16  packed 4-bit fraction per requester; requester i occupies bits [4i+3:4i].
REQ-007 grant  out  4  one-hot owner of the shared timer; all-zero when idle.
REQ-008 busy  out  1  high while a timing run is active (grant != 0).
REQ-009 done_out  out  4  one-cycle pulse to the owner when its period completes.
REQ-010 halfway_out  out  4  one-cycle pulse to the owner at the period midpoint.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-012 In IDLE with req != 0, at the next edge the block SHALL grant the request selected round-robin from rr_ptr and latch that requester's fraction into fraction_lat[3:0]. It SHALL set counter=0, load the period and enter RUN. rr_ptr is the requester index after the previous owner.
REQ-013 Round-robin search SHALL start at rr_ptr and wrap 3->0; after reset rr_ptr=0.
REQ-014 Period P SHALL be CLOCK_FREQ/fraction_lat (integer division, 32-bit); fraction_lat=0 SHALL give P=CLOCK_FREQ; P is fixed for the whole run.
REQ-015 In RUN, counter SHALL increment by 1 per cycle while counter < P-1; grant SHALL stay high for exactly P cycles.
REQ-016 When counter == P-1 at an edge, the block SHALL assert done_out[owner] for one cycle, clear grant, set counter=0, set rr_ptr=owner+1 mod 4 and return to IDLE.
REQ-017 When counter == P/2-1 in RUN, the block SHALL assert halfway_out[owner] for exactly one cycle; no halfway pulse if P/2-1 would be negative (P=1).
REQ-018 If req[owner] is low at an edge in RUN, the run SHALL abort. Abort: grant cleared, no done or halfway pulse, rr_ptr=owner+1, return to IDLE. Abort takes priority over completion in the same cycle.
REQ-019 Changes to fraction_in or to other req bits during RUN SHALL have no effect on the active run.
REQ-020 After any run ends, the block SHALL spend at least one cycle in IDLE before the next grant.
REQ-021 done_out and halfway_out SHALL be one-hot or zero; grant SHALL be one-hot or zero at all times.

Reset
REQ-022 Asserting reset at any time SHALL immediately force state=IDLE, grant=0, busy=0, done_out=0, halfway_out=0, counter=0, rr_ptr=0, fraction_lat=0; a run in progress is discarded with no pulses.
REQ-023 After reset deasserts, the first grant SHALL occur no earlier than the first edge with reset low and req != 0.

Structure
REQ-024 State encodings, NUM_REQ and the default CLOCK_FREQ SHALL live in the shared game timing package.
REQ-025 Period computation and counting SHALL be a sub-module frac_timer_core with inputs: clk, reset, load, fraction[3:0]. Its outputs are a one-cycle expired pulse and a one-cycle mid pulse. The arbiter owns only the FSM, rr_ptr and the output steering.

Verification (CLOCK_FREQ=16 for all scenarios)
REQ-026 req=0001, fraction0=4 -> grant=0001 one cycle later for 4 cycles. halfway_out[0] pulses in the 2nd grant cycle. done_out[0] pulses in the first cycle after grant falls.
REQ-027 req=1111 held, all fractions=8 -> grants in order 0001,0010,0100,1000,0001. Each grant lasts 2 cycles, with 1 IDLE cycle between grants.
REQ-028 req=0010, fraction1=0 -> grant=0010 for 16 cycles, halfway pulse at counter=7, one done pulse.
REQ-029 Owner 0 with fraction=2 (P=8), drop req[0] at counter=3 -> grant clears at next edge, no done_out, next grant goes to the lowest pending index >=1.
REQ-030 reset asserted asynchronously mid-RUN at counter=5 -> grant=0, done_out=0, halfway_out=0 immediately. With req=0100 held after release, first grant is 0100 (rr_ptr=0 search).
